// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM port arbiter and its round-robin picker.
package sdram_arb_pkg;

    localparam int DW = 16;
    localparam int BW = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REFR} arb_state_t;

    // Index width that stays legal (>= 1 bit) for a single-entry pool.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    int   j;
    logic hit;

    always_comb begin
        grant = '0;
        index = '0;
        hit   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!hit && req[j]) begin
                hit      = 1'b1;
                grant[j] = 1'b1;
                index    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// One-in-flight arbiter in front of the SDRAM controller; requester 0 has fixed priority.
// Define SDRAM_ARB_REFRESH_EN to add the periodic refresh request and the REFR state.
//
// state | meaning
// IDLE  | arbitrate; refresh pending beats any requester
// ISSUE | SD_REQ strobe cycle, command fields stable
// WAIT  | waiting for SD_DONE or timeout, then ACK (+ERR on timeout)
// REFR  | SD_REFRESH strobe, then wait for SD_DONE or timeout, no ACK
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int AW          = 24,
    parameter int REFRESH_CYC = 780,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    input  logic [N_REQ*BW-1:0] be,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic [DW-1:0]       rdata,
    output logic                sd_req,
    output logic                sd_we,
    output logic [AW-1:0]       sd_addr,
    output logic [DW-1:0]       sd_wdata,
    output logic [BW-1:0]       sd_be,
    output logic                sd_refresh,
    input  logic                sd_done,
    input  logic [DW-1:0]       sd_rdata
);

    localparam int WW = idx_w(N_REQ);
    localparam int RW = idx_w(N_REQ - 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_t     state;
    logic [WW-1:0]  win;
    logic [WW-1:0]  rr_ptr;
    logic [TW-1:0]  tcnt;

    logic [N_REQ-1:0] elig;
    logic [N_REQ-2:0] rr_grant;
    logic [RW-1:0]    rr_idx;
    logic [RW-1:0]    rr_start;
    logic             sel_valid;
    logic [WW-1:0]    sel_idx;
    logic [WW-1:0]    next_ptr;

    // The requester being ACKed this cycle has not had a chance to drop REQ yet.
    assign elig     = req & ~ack;
    assign rr_start = RW'(rr_ptr - WW'(1));

    rr_pick #(.N(N_REQ - 1), .IW(RW)) u_rr_pick (
        .req   (elig[N_REQ-1:1]),
        .ptr   (rr_start),
        .grant (rr_grant),
        .index (rr_idx)
    );

    assign sel_valid = elig[0] | (|rr_grant);
    assign sel_idx   = elig[0] ? '0 : WW'(rr_idx) + WW'(1);
    assign next_ptr  = (sel_idx == WW'(N_REQ - 1)) ? WW'(1) : sel_idx + WW'(1);

`ifdef SDRAM_ARB_REFRESH_EN
    localparam int RCW = idx_w(REFRESH_CYC);

    logic [RCW-1:0] rcnt;
    logic           ref_pend;
    logic           ref_take;

    assign ref_take = (state == IDLE) && ref_pend;

    // Free-running: keeps counting through accesses; a second expiry is not queued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt     <= '0;
            ref_pend <= 1'b0;
        end else if (rcnt == RCW'(REFRESH_CYC - 1)) begin
            rcnt     <= '0;
            ref_pend <= 1'b1;
        end else begin
            rcnt <= rcnt + RCW'(1);
            if (ref_take)
                ref_pend <= 1'b0;
        end
    end
`else
    assign sd_refresh = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            win      <= '0;
            rr_ptr   <= WW'(1);
            tcnt     <= '0;
            ack      <= '0;
            err      <= 1'b0;
            rdata    <= '0;
            sd_req   <= 1'b0;
            sd_we    <= 1'b0;
            sd_addr  <= '0;
            sd_wdata <= '0;
            sd_be    <= '0;
`ifdef SDRAM_ARB_REFRESH_EN
            sd_refresh <= 1'b0;
`endif
        end else begin
            ack    <= '0;
            err    <= 1'b0;
            sd_req <= 1'b0;
            case (state)
                IDLE: begin
`ifdef SDRAM_ARB_REFRESH_EN
                    if (ref_pend) begin
                        sd_refresh <= 1'b1;
                        tcnt       <= TW'(1);
                        state      <= REFR;
                    end else
`endif
                    if (sel_valid) begin
                        win      <= sel_idx;
                        sd_req   <= 1'b1;
                        sd_we    <= we[sel_idx];
                        sd_addr  <= addr[int'(sel_idx)*AW +: AW];
                        sd_wdata <= wdata[int'(sel_idx)*DW +: DW];
                        sd_be    <= be[int'(sel_idx)*BW +: BW];
                        tcnt     <= TW'(1);
                        state    <= ISSUE;
                        if (sel_idx != '0)
                            rr_ptr <= next_ptr;
                    end
                end
                ISSUE: begin
                    tcnt  <= tcnt + TW'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (sd_done) begin
                        ack   <= N_REQ'(1) << win;
                        tcnt  <= '0;
                        state <= IDLE;
                        if (!sd_we)
                            rdata <= sd_rdata;
                    end else if (tcnt == TW'(TIMEOUT)) begin
                        ack   <= N_REQ'(1) << win;
                        err   <= 1'b1;
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                REFR: begin
`ifdef SDRAM_ARB_REFRESH_EN
                    // sd_refresh doubles as the strobe-phase flag; DONE is ignored during it.
                    if (sd_refresh) begin
                        sd_refresh <= 1'b0;
                        tcnt       <= tcnt + TW'(1);
                    end else if (sd_done || tcnt == TW'(TIMEOUT)) begin
                        tcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed literal cases plus randomized traffic vs a transaction model.
module tb_sdram_port_arbiter;

    localparam int N    = 3;
    localparam int AW   = 24;
    localparam int TMO  = 20;
    localparam int RCYC = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*16-1:0] wdata = '0;
    logic [N*2-1:0]  be = '0;
    logic [N-1:0]    ack;
    logic            err;
    logic [15:0]     rdata;
    logic            sd_req, sd_we, sd_refresh;
    logic [AW-1:0]   sd_addr;
    logic [15:0]     sd_wdata;
    logic [1:0]      sd_be;
    logic            sd_done = 1'b0;
    logic [15:0]     sd_rdata = '0;

    int checks = 0;
    int failures = 0;

    sdram_port_arbiter #(.N_REQ(N), .AW(AW), .REFRESH_CYC(RCYC), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ack(ack), .err(err), .rdata(rdata), .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr),
        .sd_wdata(sd_wdata), .sd_be(sd_be), .sd_refresh(sd_refresh), .sd_done(sd_done),
        .sd_rdata(sd_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction model: an access or refresh is "in flight" for a number of edges;
    // it completes on the first DONE at least two edges after issue, or at TMO edges.
    bit           m_busy = 0, m_is_ref = 0, m_rpend = 0, m_we = 0;
    int           m_age = 0, m_idx = 0, m_ptr = 1, m_edge = 0, m_win = 0, m_j = 0;
    logic [N-1:0] m_prev, m_elig;
    logic [N-1:0] e_ack = '0;
    logic         e_err = 0, e_sdreq = 0, e_sdref = 0, e_sdwe = 0;
    logic [15:0]  e_rdata = '0, e_wdata = '0;
    logic [AW-1:0] e_addr = '0;
    logic [1:0]   e_be = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_is_ref = 0; m_rpend = 0; m_age = 0; m_ptr = 1; m_edge = 0;
            e_ack = '0; e_err = 0; e_sdreq = 0; e_sdref = 0; e_rdata = '0;
        end else begin
            m_prev = e_ack;
            e_ack = '0; e_err = 0; e_sdreq = 0; e_sdref = 0;
            if (m_busy) begin
                m_age++;
                if (m_age >= 2 && (sd_done || m_age == TMO)) begin
                    m_busy = 0;
                    if (!m_is_ref) begin
                        e_ack[m_idx] = 1'b1;
                        if (!sd_done) e_err = 1'b1;
                        else if (!m_we) e_rdata = sd_rdata;
                    end
                end
            end else if (m_rpend) begin
                m_busy = 1; m_is_ref = 1; m_age = 0; e_sdref = 1; m_rpend = 0;
            end else begin
                m_elig = req & ~m_prev;
                m_win = -1;
                if (m_elig[0]) m_win = 0;
                else for (int k = 0; k < N - 1; k++) begin
                    m_j = 1 + ((m_ptr - 1 + k) % (N - 1));
                    if (m_win < 0 && m_elig[m_j]) m_win = m_j;
                end
                if (m_win >= 0) begin
                    m_busy = 1; m_is_ref = 0; m_age = 0; m_idx = m_win; m_we = we[m_win];
                    e_sdreq = 1; e_sdwe = we[m_win];
                    e_addr = addr[m_win*AW +: AW];
                    e_wdata = wdata[m_win*16 +: 16];
                    e_be = be[m_win*2 +: 2];
                    if (m_win != 0) m_ptr = (m_win == N - 1) ? 1 : m_win + 1;
                end
            end
`ifdef SDRAM_ARB_REFRESH_EN
            if ((m_edge + 1) % RCYC == 0) m_rpend = 1;
`endif
            m_edge++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("m_ack", 32'(ack), 32'(e_ack));
            chk("m_err", 32'(err), 32'(e_err));
            chk("m_rdata", 32'(rdata), 32'(e_rdata));
            chk("m_sd_req", 32'(sd_req), 32'(e_sdreq));
            chk("m_sd_refresh", 32'(sd_refresh), 32'(e_sdref));
            if (e_sdreq) begin
                chk("m_sd_we", 32'(sd_we), 32'(e_sdwe));
                chk("m_sd_addr", 32'(sd_addr), 32'(e_addr));
                chk("m_sd_wdata", 32'(sd_wdata), 32'(e_wdata));
                chk("m_sd_be", 32'(sd_be), 32'(e_be));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; we = '0; sd_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    int grants[$];
    int exp_order[10] = '{0, 1, 0, 2, 0, 1, 2, 1, 2, 1};
    int t1, t2, n;
    int done_div;

    initial begin
        do_reset();
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);

        // single read on requester 1
        @(negedge clk);
        req = 3'b010; addr[1*AW +: AW] = 24'h001234;
        sample();
        chk("t1_sd_req", 32'(sd_req), 32'h1);
        chk("t1_sd_addr", 32'(sd_addr), 32'h001234);
        chk("t1_sd_we", 32'(sd_we), 32'h0);
        repeat (4) @(negedge clk);
        sd_done = 1'b1; sd_rdata = 16'hBEEF;
        sample();
        chk("t1_ack", 32'(ack), 32'h2);
        chk("t1_rdata", 32'(rdata), 32'hBEEF);
        @(negedge clk);
        sd_done = 1'b0;
        sample();
        chk("t1_no_regrant", 32'(sd_req), 32'h0);
        @(negedge clk);
        req = '0;

        // write on requester 2 leaves RDATA alone
        @(negedge clk);
        req = 3'b100; we = 3'b100;
        wdata[2*16 +: 16] = 16'h55AA; be[2*2 +: 2] = 2'b01;
        sample();
        chk("t3_sd_we", 32'(sd_we), 32'h1);
        chk("t3_sd_wdata", 32'(sd_wdata), 32'h55AA);
        chk("t3_sd_be", 32'(sd_be), 32'h1);
        repeat (2) @(negedge clk);
        sd_done = 1'b1; sd_rdata = 16'h1234;
        sample();
        chk("t3_ack", 32'(ack), 32'h4);
        chk("t3_rdata_kept", 32'(rdata), 32'hBEEF);
        @(negedge clk);
        sd_done = 1'b0; req = '0; we = '0;

        // timeout: no DONE ever
        do_reset();
        @(negedge clk);
        req = 3'b001; addr[0 +: AW] = 24'hABCDEF; sd_rdata = 16'h9999;
        sample();
        chk("t4_sd_req", 32'(sd_req), 32'h1);
        for (int k = 1; k <= TMO; k++) begin
            sample();
            if (k == TMO - 1) chk("t4_ack_early", 32'(ack), 32'h0);
            if (k == TMO) begin
                chk("t4_ack", 32'(ack), 32'h1);
                chk("t4_err", 32'(err), 32'h1);
                chk("t4_rdata_kept", 32'(rdata), 32'h0);
            end
        end
        @(negedge clk);
        req = 3'b010; addr[1*AW +: AW] = 24'h000777;
        sample();
        chk("t4_next_sd_req", 32'(sd_req), 32'h1);
        chk("t4_next_addr", 32'(sd_addr), 32'h000777);
        @(negedge clk);
        @(negedge clk);
        sd_done = 1'b1;
        sample();
        chk("t4_next_ack", 32'(ack), 32'h2);
        chk("t4_next_err", 32'(err), 32'h0);
        @(negedge clk);
        sd_done = 1'b0; req = '0;

        // reset while waiting: outputs clear at once, late DONE ignored
        @(negedge clk);
        req = 3'b010;
        sample();
        chk("t6_sd_req", 32'(sd_req), 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ack", 32'(ack), 32'h0);
        chk("t6_rst_sd_addr", 32'(sd_addr), 32'h0);
        chk("t6_rst_rdata", 32'(rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; req = '0; sd_done = 1'b1;
        sample();
        chk("t6_late_ack", 32'(ack), 32'h0);
        @(negedge clk);
        sd_done = 1'b0;
        sample();
        chk("t6_late_ack2", 32'(ack), 32'h0);

        // REQ[0] held wins whenever eligible; its own ACK cycle hands one slot to round robin
        do_reset();
        @(negedge clk);
        req = 3'b111;
        for (int g = 0; g < 10; g++) begin
            n = 0;
            while (!sd_req && n < 10) begin
                sample();
                n++;
            end
            chk("t2_sd_req_seen", 32'(sd_req), 32'h1);
            @(negedge clk);
            @(negedge clk);
            sd_done = 1'b1;
            sample();
            grants.push_back((ack == 3'b001) ? 0 : (ack == 3'b010) ? 1 : (ack == 3'b100) ? 2 : -1);
            @(negedge clk);
            sd_done = 1'b0;
            if (g == 5) req[0] = 1'b0;
        end
        for (int g = 0; g < 10; g++)
            chk($sformatf("t2_grant%0d", g), 32'(grants[g]), 32'(exp_order[g]));
        @(negedge clk);
        req = '0;

`ifdef SDRAM_ARB_REFRESH_EN
        do_reset();
        sd_done = 1'b1;
        t1 = 0; t2 = 0;
        for (int k = 1; k <= 3 * RCYC && t2 == 0; k++) begin
            sample();
            if (sd_refresh) begin
                if (t1 == 0) t1 = k;
                else t2 = k;
            end
        end
        chk("t5_ref_first", 32'(t1), 32'(RCYC + 1));
        chk("t5_ref_period", 32'(t2 - t1), 32'(RCYC));
        @(negedge clk);
        sd_done = 1'b0;
`endif

        // randomized traffic with varying DONE rates, including none (timeouts)
        for (int seg = 0; seg < 6; seg++) begin
            done_div = (seg % 3 == 0) ? 2 : (seg % 3 == 1) ? 6 : 0;
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    if (req[i] && ack[i]) req[i] = 1'b0;
                    else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
                    else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
                    we[i] = 1'($urandom_range(0, 1));
                    addr[i*AW +: AW] = 24'($urandom);
                    wdata[i*16 +: 16] = 16'($urandom);
                    be[i*2 +: 2] = 2'($urandom);
                end
                sd_done = (done_div != 0) && ($urandom_range(0, done_div - 1) == 0);
                sd_rdata = 16'($urandom);
            end
        end
        @(negedge clk);
        req = '0; sd_done = 1'b0;
        repeat (TMO + 5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
